// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : usb_tx_pkg
//  Brief   : Shared constants, state type and output-ordering helpers for the
//            USB transmit CRC generator.
//  Rev     : 1.0  initial release
// ============================================================================
package usb_tx_pkg;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam int          TOKEN_BITS = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT5  = 2'd1,
    SHIFT16 = 2'd2,
    DONE    = 2'd3
  } crc_state_t;

  // The LFSR MSB is the first CRC bit on the wire, so transmit order is the
  // complemented register bit-reversed.
  function automatic logic [4:0] crc5_tx(input logic [4:0] lfsr);
    logic [4:0] res;
    for (int i = 0; i < 5; i++) res[i] = ~lfsr[4-i];
    return res;
  endfunction

  function automatic logic [15:0] crc16_tx(input logic [15:0] lfsr);
    logic [15:0] res;
    for (int i = 0; i < 16; i++) res[i] = ~lfsr[15-i];
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_serial_lfsr.sv
`default_nettype none
// ============================================================================
//  Module  : usb_serial_lfsr
//  Brief   : One-bit-per-clock Galois CRC register with load and shift.
//  Rev     : 1.0  initial release
// ============================================================================
module usb_serial_lfsr #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] lfsr_next
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             fb;

  always_comb begin
    fb     = lfsr_q[WIDTH-1] ^ din;
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = INIT;
    end else if (shift) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  // The next value lets the owner capture the result on the final shift edge.
  assign lfsr_next = lfsr_d;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

endmodule
`default_nettype wire

// File: rtl/usb_tx_crc_gen.sv
`default_nettype none
// ============================================================================
//  Module  : usb_tx_crc_gen
//  Brief   : Serial CRC5/CRC16 generator for USB token and data packets.
//  Rev     : 1.0  initial release
// ============================================================================
module usb_tx_crc_gen
  import usb_tx_pkg::*;
#(
  parameter int DATA_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_crc5,
  input  logic                    start_crc16,
  input  logic [TOKEN_BITS-1:0]   token_field,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [3:0]              data_len,
  output logic                    busy,
  output logic                    done,
  output logic [4:0]              crc5,
  output logic [15:0]             crc16
);

  localparam int         DATA_W  = 8 * DATA_BYTES;
  localparam logic [3:0] MAX_LEN = 4'(DATA_BYTES);

  crc_state_t            state_q, state_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [TOKEN_BITS-1:0] token_q, token_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [3:0]            len_q, len_d;
  logic [4:0]            crc5_q, crc5_d;
  logic [15:0]           crc16_q, crc16_d;
  logic                  load5, shift5, load16, shift16;
  logic [4:0]            lfsr5_next;
  logic [15:0]           lfsr16_next;
  logic [6:0]            last16;

  assign last16 = {len_q, 3'b000} - 7'd1;

  usb_serial_lfsr #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_lfsr5 (
    .clk       (clk),
    .rst       (rst),
    .load      (load5),
    .shift     (shift5),
    .din       (token_q[0]),
    .lfsr_next (lfsr5_next)
  );

  usb_serial_lfsr #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_lfsr16 (
    .clk       (clk),
    .rst       (rst),
    .load      (load16),
    .shift     (shift16),
    .din       (data_q[0]),
    .lfsr_next (lfsr16_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    token_d = token_q;
    data_d  = data_q;
    len_d   = len_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    load5   = 1'b0;
    shift5  = 1'b0;
    load16  = 1'b0;
    shift16 = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_crc16) begin
          data_d  = data;
          len_d   = (data_len > MAX_LEN) ? MAX_LEN : data_len;
          load16  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT16;
        end else if (start_crc5) begin
          token_d = token_field;
          load5   = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT5;
        end
      end
      SHIFT5: begin
        // Latched fields shift right so bit 0 is always the next bit to send.
        shift5  = 1'b1;
        token_d = token_q >> 1;
        cnt_d   = cnt_q + 7'd1;
        if (cnt_q == 7'(TOKEN_BITS - 1)) begin
          crc5_d  = crc5_tx(lfsr5_next);
          state_d = DONE;
        end
      end
      SHIFT16: begin
        if (len_q == 4'd0) begin
          crc16_d = crc16_tx(lfsr16_next);
          state_d = DONE;
        end else begin
          shift16 = 1'b1;
          data_d  = data_q >> 1;
          cnt_d   = cnt_q + 7'd1;
          if (cnt_q == last16) begin
            crc16_d = crc16_tx(lfsr16_next);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      token_q <= '0;
      data_q  <= '0;
      len_q   <= '0;
      crc5_q  <= '0;
      crc16_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      token_q <= token_d;
      data_q  <= data_d;
      len_q   <= len_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  assign busy  = (state_q == SHIFT5) || (state_q == SHIFT16);
  assign done  = (state_q == DONE);
  assign crc5  = crc5_q;
  assign crc16 = crc16_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_crc_gen.sv
`default_nettype none
// ============================================================================
//  Module  : tb_usb_tx_crc_gen
//  Brief   : Randomized self-checking bench for usb_tx_crc_gen against a
//            reflected-form CRC reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_usb_tx_crc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_crc5;
  logic        start_crc16;
  logic [10:0] token_field;
  logic [63:0] data;
  logic [3:0]  data_len;
  logic        busy;
  logic        done;
  logic [4:0]  crc5;
  logic [15:0] crc16;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [4:0]  exp_crc5;
  logic [15:0] exp_crc16;

  usb_tx_crc_gen #(.DATA_BYTES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_crc5  (start_crc5),
    .start_crc16 (start_crc16),
    .token_field (token_field),
    .data        (data),
    .data_len    (data_len),
    .busy        (busy),
    .done        (done),
    .crc5        (crc5),
    .crc16       (crc16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reflected (LSB-first) formulation: the register already sits in wire order.
  function automatic logic [4:0] ref_crc5(input logic [10:0] t);
    logic [4:0] r;
    r = 5'h1F;
    for (int k = 0; k < 11; k++)
      r = (r[0] ^ t[k]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    return ~r;
  endfunction

  function automatic logic [15:0] ref_crc16(input logic [63:0] d, input int nbytes);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int k = 0; k < 8 * nbytes; k++)
      r = (r[0] ^ d[k]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return ~r;
  endfunction

  task automatic do_run(input string tag, input bit s5, input bit s16,
                        input logic [10:0] tok, input logic [63:0] d, input logic [3:0] len);
    int         exp_edges, edges, busy_cnt, nbytes;
    logic [4:0]  e5;
    logic [15:0] e16;
    nbytes = (len > 4'd8) ? 8 : int'(len);
    if (s16) begin
      e16       = ref_crc16(d, nbytes);
      e5        = exp_crc5;
      exp_edges = (nbytes == 0) ? 1 : 8 * nbytes;
    end else begin
      e5        = ref_crc5(tok);
      e16       = exp_crc16;
      exp_edges = 11;
    end
    token_field = tok;
    data        = d;
    data_len    = len;
    start_crc5  = s5;
    start_crc16 = s16;
    tick();
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    edges    = 0;
    busy_cnt = 1;
    // Requests and field changes while shifting must all be ignored.
    while (!done && edges < 300) begin
      start_crc5  = 1'($urandom);
      start_crc16 = 1'($urandom);
      token_field = 11'($urandom);
      data        = {$urandom, $urandom};
      data_len    = 4'($urandom);
      tick();
      edges++;
      if (busy) busy_cnt++;
    end
    chk({tag, "_done_edge"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_edges));
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_crc5"}, 32'(crc5), 32'(e5));
    chk({tag, "_crc16"}, 32'(crc16), 32'(e16));
    exp_crc5  = e5;
    exp_crc16 = e16;
    start_crc5  = 1'b1;
    start_crc16 = 1'b1;
    tick();
    start_crc5  = 1'b0;
    start_crc16 = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_no_restart"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start_crc5  = 1'b0;
    start_crc16 = 1'b0;
    token_field = '0;
    data        = '0;
    data_len    = '0;
    exp_crc5    = '0;
    exp_crc16   = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_crc5", 32'(crc5), 32'd0);
    chk("rst_crc16", 32'(crc16), 32'd0);
    rst = 1'b0;
    tick();

    do_run("setup", 1'b1, 1'b0, 11'h000, 64'h0, 4'd0);
    chk("setup_crc5_known", 32'(crc5), 32'h02);

    do_run("zlen", 1'b0, 1'b1, 11'h0, {$urandom, $urandom}, 4'd0);
    chk("zlen_crc16_known", 32'(crc16), 32'h0000);

    do_run("p8", 1'b0, 1'b1, 11'h0, 64'h0706050403020100, 4'd8);
    do_run("p15", 1'b0, 1'b1, 11'h0, 64'h0706050403020100, 4'd15);
    chk("clamp_same", 32'(crc16), 32'(ref_crc16(64'h0706050403020100, 8)));

    do_run("both", 1'b1, 1'b1, 11'($urandom), {$urandom, $urandom}, 4'($urandom_range(1, 8)));

    for (int i = 0; i < 12; i++) begin
      do_run("rnd5", 1'b1, 1'b0, 11'($urandom), 64'h0, 4'd0);
      do_run("rnd16", 1'b0, 1'b1, 11'h0, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
    end

    // Abort a CRC16 run partway through the payload.
    token_field = '0;
    data        = {$urandom, $urandom};
    data_len    = 4'd8;
    start_crc16 = 1'b1;
    tick();
    start_crc16 = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_crc16", 32'(crc16), 32'd0);
    chk("abort_crc5", 32'(crc5), 32'd0);
    exp_crc5  = '0;
    exp_crc16 = '0;
    rst = 1'b0;
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    tick();
    chk("abort_idle", 32'(busy), 32'd0);
    do_run("fresh", 1'b0, 1'b1, 11'h0, {$urandom, $urandom}, 4'd8);
    do_run("fresh5", 1'b1, 1'b0, 11'($urandom), 64'h0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_tx_crc_gen.md
# usb_tx_crc_gen

Serial CRC generator for the USB transmit path. Latches an 11-bit token field or up to 64 bits of payload, computes CRC5 or CRC16 one bit per clock, and presents the complemented, transmit-ordered result. It feeds the transmit control unit, which loads `crc5` and `crc16` into the transmit shift register alongside sync, PID and data.

## Interface
Parameters:
- `DATA_BYTES`, default 8: maximum payload bytes; the payload bus is `8*DATA_BYTES` bits wide.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_crc5`  in  1  request a CRC5 over `token_field`; sampled only in IDLE.
- `start_crc16`  in  1  request a CRC16 over `data`; sampled only in IDLE.
- `token_field`  in  11  `{endp[3:0], addr[6:0]}`; bit 0 is transmitted first.
- `data`  in  64  payload; byte 0 is `data[7:0]`, bit 0 is transmitted first.
- `data_len`  in  4  payload byte count, 0–8; values above 8 are treated as 8.
- `busy`  out  1  high while shifting.
- `done`  out  1  one-cycle pulse when the result is valid.
- `crc5`  out  5  CRC5 result; bit 0 is transmitted first.
- `crc16`  out  16  CRC16 result; bit 0 is transmitted first.

## Operation
- States: IDLE, SHIFT5, SHIFT16, DONE.
- **IDLE, start_crc16 high:**
  - latch `data` and the clamped `data_len`;
  - load LFSR16 = 0xFFFF;
  - go to SHIFT16.
- **IDLE, start_crc5 high (start_crc16 low):**
  - latch `token_field`;
  - load LFSR5 = 5'b11111;
  - go to SHIFT5.
- **Both starts high in the same cycle:** CRC16 wins and the CRC5 request is dropped.
- **Start while not in IDLE:** ignored, with no queuing.
- **CRC5 step:**
  - fb = lfsr5[4] ^ bit;
  - lfsr5 = {lfsr5[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00).
- **CRC16 step:**
  - fb = lfsr16[15] ^ bit;
  - lfsr16 = {lfsr16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000).
- **Bit order:** bit k of the latched field is consumed in shift cycle k, LSB first. The bit counter is 7 bits wide.
  - SHIFT5 runs exactly 11 cycles.
  - SHIFT16 runs 8·len cycles.
- **Zero-length payload (len = 0):** SHIFT16 consumes one cycle and shifts nothing, so the result is ~0xFFFF = 0x0000.
- **Exit from SHIFT:** after the last bit, go to DONE.
  - Pulse `done` and update the output register for the active CRC type only.
  - `crc5[i] = ~lfsr5[4-i]`.
  - `crc16[i] = ~lfsr16[15-i]`.
  - The other output holds its value.
- **DONE → IDLE** unconditionally on the next cycle.
- **Output hold:** outputs hold until the next completion of the same type.

## Timing
- **Reset values:**
  - `busy` = 0, `done` = 0, `crc5` = 5'h00, `crc16` = 16'h0000;
  - state = IDLE; counter and LFSRs cleared.
- **Reset mid-operation:** aborts on that edge. No `done` is produced and the outputs return to their reset values.
- **Start edge** is edge 0.
  - `busy` goes high after edge 0.
  - CRC5: `busy` falls and `done` is high in the cycle after edge 11.
  - CRC16: the same happens after edge 8·len (edge 1 when len = 0).
- **Output update:** `crc5`/`crc16` change on the same edge that raises `done` and are stable while `done` is high.
- **Back-to-back:** a start asserted during the `done` cycle is ignored. The earliest accepted restart is the cycle after `done`, with state IDLE.
- **Latching:** inputs are latched at the start edge. Changes to `token_field`, `data` or `data_len` while busy have no effect.

## Structure
- Shared package `usb_tx_pkg` holds:
  - `CRC5_POLY` = 5'h05 and `CRC16_POLY` = 16'h8005;
  - `CRC5_INIT` and `CRC16_INIT`;
  - `TOKEN_BITS` = 11;
  - the `crc_state_t` enum {IDLE, SHIFT5, SHIFT16, DONE}.
- One natural sub-module: `usb_serial_lfsr`, a parameterized width/poly/init LFSR with `load`, `shift` and `din` inputs. It is instantiated twice, once for CRC5 and once for CRC16. The FSM, counter and output registers stay in `usb_tx_crc_gen`.

## Test plan
- SETUP token, addr 0, endp 0: `token_field` = 11'h000, pulse `start_crc5` → `done` 12 cycles later, `crc5` = 5'h02, `busy` high for 11 cycles.
- Zero-length DATA: `data_len` = 0, pulse `start_crc16` → `done` in the cycle after edge 1, `crc16` = 16'h0000.
- 8-byte payload 0x0706050403020100: `data_len` = 8 → `done` after edge 64, `crc16` equals the bench software model (same poly, init, complement, ordering). Then repeat with `data_len` = 15 and expect an identical result, which checks the clamp.
- Simultaneous start: `start_crc5` and `start_crc16` high together → only a CRC16 run of 8·len cycles; `crc5` is unchanged.
- Start while busy: pulse `start_crc5` at cycle 5 of a CRC16 run, and change `data` mid-run → single `done`, CRC16 matches the data latched at the start, no CRC5 run follows.
- Reset mid-run: assert `rst` at shift cycle 30 → the next cycle shows `busy` = 0 and `crc16` = 0; no `done`; a fresh start afterwards completes correctly.
